// File: rtl/arm_regfile_pkg.sv
// Shared constants and helpers for the ARM register file with busy scoreboard.
package arm_regfile_pkg;

    localparam int DEF_WORD_LEN   = 32;
    localparam int DEF_WORD_COUNT = 16;
    localparam int DEF_READ_PORTS = 3;
    localparam int PC_INDEX       = DEF_WORD_COUNT - 1;

    function automatic int addrWidth(input int wordCount);
        return (wordCount > 1) ? $clog2(wordCount) : 1;
    endfunction

    function automatic int pcIndex(input int wordCount);
        return wordCount - 1;
    endfunction

endpackage

// File: rtl/arm_regfile_sb_if.sv
// Register-file bus: read ports, write-back, issue and scoreboard status.
interface arm_regfile_sb_if
    import arm_regfile_pkg::*;
#(
    parameter int WordLen   = DEF_WORD_LEN,
    parameter int WordCount = DEF_WORD_COUNT,
    parameter int ReadPorts = DEF_READ_PORTS,
    parameter int AW        = addrWidth(WordCount)
);

    logic [WordLen-1:0]           pcIn;
    logic [ReadPorts*AW-1:0]      readRegister;
    logic [ReadPorts*WordLen-1:0] readData;
    logic [ReadPorts-1:0]         readBusy;
    logic                         regWrite;
    logic [AW-1:0]                writeRegister;
    logic [WordLen-1:0]           writeData;
    logic                         issueValid;
    logic [AW-1:0]                issueRegister;
    logic                         anyBusy;
    logic [AW:0]                  busyCount;

    modport master (
        output pcIn, readRegister, regWrite, writeRegister, writeData,
               issueValid, issueRegister,
        input  readData, readBusy, anyBusy, busyCount
    );

    modport slave (
        input  pcIn, readRegister, regWrite, writeRegister, writeData,
               issueValid, issueRegister,
        output readData, readBusy, anyBusy, busyCount
    );

endinterface

// File: rtl/arm_regfile_sb_scoreboard.sv
// Per-register busy bits: issue sets, write-back clears, issue wins on a tie.
module arm_scoreboard
    import arm_regfile_pkg::*;
#(
    parameter int WordCount = DEF_WORD_COUNT,
    parameter int AW        = addrWidth(WordCount)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issueValid,
    input  logic [AW-1:0]        issueRegister,
    input  logic                 regWrite,
    input  logic [AW-1:0]        writeRegister,
    output logic [WordCount-1:0] busy,
    output logic                 anyBusy,
    output logic [AW:0]          busyCount
);

    localparam int PcIndex = pcIndex(WordCount);

    logic [WordCount-1:0] busyNext;
    logic [AW:0]          countNext;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busyNext  = busy;
        countNext = '0;
        if (regWrite && int'(writeRegister) < PcIndex)
            busyNext[writeRegister] = 1'b0;
        // Applied after the clear so a new producer supersedes the retiring one.
        if (issueValid && int'(issueRegister) < PcIndex)
            busyNext[issueRegister] = 1'b1;
        busyNext[PcIndex] = 1'b0;
        for (int i = 0; i < WordCount; i++)
            countNext = countNext + {{AW{1'b0}}, busyNext[i]};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= '0;
            busyCount <= '0;
        end else begin
            busy      <= busyNext;
            busyCount <= countNext;
        end
    end

    assign anyBusy = |busy;

endmodule

// File: rtl/arm_regfile_sb.sv
// ARM register file: N combinational read ports, one write-back port, busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to readers.
module arm_regfile_sb
    import arm_regfile_pkg::*;
#(
    parameter int WordLen   = DEF_WORD_LEN,
    parameter int WordCount = DEF_WORD_COUNT,
    parameter int ReadPorts = DEF_READ_PORTS
) (
    input logic             clk,
    input logic             rst,
    arm_regfile_sb_if.slave bus
);

    localparam int AW      = addrWidth(WordCount);
    localparam int PcIndex = pcIndex(WordCount);

    logic [WordLen-1:0]   regs [PcIndex];
    logic [WordCount-1:0] busy;
    logic [AW-1:0]        rdAddr [ReadPorts];

    // NOTE: the storage array is reset explicitly because reads after reset must return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PcIndex; i++)
                regs[i] <= '0;
        end else if (bus.regWrite && int'(bus.writeRegister) < PcIndex) begin
            regs[bus.writeRegister] <= bus.writeData;
        end
    end

    always_comb begin
        for (int k = 0; k < ReadPorts; k++)
            rdAddr[k] = bus.readRegister[k*AW +: AW];
    end

    always_comb begin
        bus.readData = '0;
        bus.readBusy = '0;
        for (int k = 0; k < ReadPorts; k++) begin
            if (int'(rdAddr[k]) == PcIndex) begin
                bus.readData[k*WordLen +: WordLen] = bus.pcIn;
            end else if (int'(rdAddr[k]) < PcIndex) begin
                bus.readData[k*WordLen +: WordLen] = regs[rdAddr[k]];
                bus.readBusy[k]                    = busy[rdAddr[k]];
`ifdef REGFILE_BYPASS_EN
                if (bus.regWrite && bus.writeRegister == rdAddr[k]) begin
                    bus.readData[k*WordLen +: WordLen] = bus.writeData;
                    bus.readBusy[k]                    = 1'b0;
                end
`endif
            end
        end
    end

    arm_scoreboard #(
        .WordCount(WordCount),
        .AW       (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issueValid   (bus.issueValid),
        .issueRegister(bus.issueRegister),
        .regWrite     (bus.regWrite),
        .writeRegister(bus.writeRegister),
        .busy         (busy),
        .anyBusy      (bus.anyBusy),
        .busyCount    (bus.busyCount)
    );

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Scoreboard-style bench for arm_regfile_sb: driver queues expectations, monitor compares at negedge.
module tb_arm_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {K_DATA, K_BUSY, K_ANY, K_COUNT} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        int          port;
        logic [31:0] value;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    arm_regfile_sb_if #(.WordLen(32), .WordCount(16), .ReadPorts(3)) bus ();

    arm_regfile_sb #(.WordLen(32), .WordCount(16), .ReadPorts(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Monitor: outputs are stable mid-cycle, so compare everything queued at the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (expQ.size() != 0) begin
                e = expQ.pop_front();
                case (e.kind)
                    K_DATA:  act = bus.readData[e.port*32 +: 32];
                    K_BUSY:  act = {31'd0, bus.readBusy[e.port]};
                    K_ANY:   act = {31'd0, bus.anyBusy};
                    default: act = {27'd0, bus.busyCount};
                endcase
                checks++;
                if (act !== e.value) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.value);
                end
            end
        end
    end

    task automatic expect_val(input string name, input kind_t kind, input int port,
                              input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.port  = port;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        bus.readRegister = {a2, a1, a0};
    endtask

    task automatic idle();
        bus.regWrite      = 1'b0;
        bus.writeRegister = '0;
        bus.writeData     = '0;
        bus.issueValid    = 1'b0;
        bus.issueRegister = '0;
    endtask

    task automatic write_back(input logic [3:0] r, input logic [31:0] d);
        bus.regWrite      = 1'b1;
        bus.writeRegister = r;
        bus.writeData     = d;
    endtask

    task automatic issue(input logic [3:0] r);
        bus.issueValid    = 1'b1;
        bus.issueRegister = r;
    endtask

    initial begin
        int waited;
        idle();
        bus.pcIn = 32'h100;
        set_read(4'd3, 4'd15, 4'd0);
        repeat (2) cycle();

        // Reset state
        expect_val("rst_r3", K_DATA, 0, 32'h0);
        expect_val("rst_pc", K_DATA, 1, 32'h100);
        expect_val("rst_r0", K_DATA, 2, 32'h0);
        expect_val("rst_busy", K_BUSY, 0, 32'h0);
        expect_val("rst_any", K_ANY, 0, 32'h0);
        expect_val("rst_count", K_COUNT, 0, 32'h0);

        // Write R5, read it on all ports next cycle
        cycle();
        rst = 1'b1;
        write_back(4'd5, 32'hDEADBEEF);
        set_read(4'd5, 4'd5, 4'd5);
        expect_val("r5_same_cycle", K_DATA, 0, BYPASS ? 32'hDEADBEEF : 32'h0);
        cycle();
        idle();
        expect_val("r5_p0", K_DATA, 0, 32'hDEADBEEF);
        expect_val("r5_p1", K_DATA, 1, 32'hDEADBEEF);
        expect_val("r5_p2", K_DATA, 2, 32'hDEADBEEF);
        expect_val("r5_not_busy", K_COUNT, 0, 32'h0);

        // Writes and issues to the PC index are ignored; PC reads are live
        cycle();
        write_back(4'd15, 32'h1);
        issue(4'd15);
        set_read(4'd15, 4'd15, 4'd5);
        expect_val("pcw_same", K_DATA, 0, 32'h100);
        cycle();
        idle();
        bus.pcIn = 32'h104;
        expect_val("pc_live", K_DATA, 1, 32'h104);
        expect_val("pc_busy", K_BUSY, 0, 32'h0);
        expect_val("pc_count", K_COUNT, 0, 32'h0);
        expect_val("pc_any", K_ANY, 0, 32'h0);
        expect_val("r5_kept", K_DATA, 2, 32'hDEADBEEF);

        // Issue R2, then write it back
        cycle();
        issue(4'd2);
        set_read(4'd2, 4'd15, 4'd5);
        expect_val("r2_issue_same", K_BUSY, 0, 32'h0);
        cycle();
        idle();
        expect_val("r2_busy", K_BUSY, 0, 32'h1);
        expect_val("r2_count", K_COUNT, 0, 32'h1);
        expect_val("r2_any", K_ANY, 0, 32'h1);
        cycle();
        write_back(4'd2, 32'h55);
        expect_val("r2_wb_data", K_DATA, 0, BYPASS ? 32'h55 : 32'h0);
        expect_val("r2_wb_busy", K_BUSY, 0, BYPASS ? 32'h0 : 32'h1);
        expect_val("r2_wb_count", K_COUNT, 0, 32'h1);
        cycle();
        idle();
        expect_val("r2_after_data", K_DATA, 0, 32'h55);
        expect_val("r2_after_busy", K_BUSY, 0, 32'h0);
        expect_val("r2_after_count", K_COUNT, 0, 32'h0);
        expect_val("r2_after_any", K_ANY, 0, 32'h0);

        // Issue and write-back of R4 on the same edge: issue wins
        cycle();
        issue(4'd4);
        write_back(4'd4, 32'h7);
        set_read(4'd4, 4'd15, 4'd5);
        expect_val("r4_tie_same_busy", K_BUSY, 0, 32'h0);
        cycle();
        idle();
        expect_val("r4_tie_data", K_DATA, 0, 32'h7);
        expect_val("r4_tie_busy", K_BUSY, 0, 32'h1);
        expect_val("r4_tie_count", K_COUNT, 0, 32'h1);

        // R6 hazard across write-back
        cycle();
        issue(4'd6);
        set_read(4'd6, 4'd4, 4'd5);
        cycle();
        idle();
        expect_val("r6_busy", K_BUSY, 0, 32'h1);
        expect_val("r6_count", K_COUNT, 0, 32'h2);
        cycle();
        write_back(4'd6, 32'h9);
        expect_val("r6_wb_data", K_DATA, 0, BYPASS ? 32'h9 : 32'h0);
        expect_val("r6_wb_busy", K_BUSY, 0, BYPASS ? 32'h0 : 32'h1);
        expect_val("r4_other_busy", K_BUSY, 1, 32'h1);
        cycle();
        idle();
        expect_val("r6_after_data", K_DATA, 0, 32'h9);
        expect_val("r6_after_busy", K_BUSY, 0, 32'h0);
        expect_val("r6_after_count", K_COUNT, 0, 32'h1);

        // Issue R1, R2, R3 (R3 also written on its issue edge), then async reset mid-cycle
        cycle();
        issue(4'd1);
        cycle();
        issue(4'd2);
        cycle();
        issue(4'd3);
        write_back(4'd3, 32'h33);
        set_read(4'd1, 4'd2, 4'd3);
        cycle();
        idle();
        expect_val("multi_r2_data", K_DATA, 1, 32'h55);
        expect_val("multi_r3_data", K_DATA, 2, 32'h33);
        expect_val("multi_r1_busy", K_BUSY, 0, 32'h1);
        expect_val("multi_r3_busy", K_BUSY, 2, 32'h1);
        expect_val("multi_count", K_COUNT, 0, 32'h4);
        cycle();
        #2;
        rst = 1'b0;
        expect_val("arst_r1_busy", K_BUSY, 0, 32'h0);
        expect_val("arst_r2_busy", K_BUSY, 1, 32'h0);
        expect_val("arst_r2_data", K_DATA, 1, 32'h0);
        expect_val("arst_r3_data", K_DATA, 2, 32'h0);
        expect_val("arst_any", K_ANY, 0, 32'h0);
        expect_val("arst_count", K_COUNT, 0, 32'h0);
        cycle();
        rst = 1'b1;
        set_read(4'd5, 4'd4, 4'd15);
        expect_val("post_rst_r5", K_DATA, 0, 32'h0);
        expect_val("post_rst_r4", K_DATA, 1, 32'h0);
        expect_val("post_rst_pc", K_DATA, 2, 32'h104);

        cycle();
        waited = 0;
        while (expQ.size() != 0 && waited < 20) begin
            cycle();
            waited++;
        end
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_regfile_sb.md
Name: arm_regfile_sb

Overview:
Parametrised ARM register file with N read ports, one rising-edge write port, and a per-register busy scoreboard for pipeline hazard detection. Sits between ID (reads, issue) and WB (write-back). Index WordCount-1 is the PC and returns the live PC value.

Parameters:
WordLen, 32, data width in bits
WordCount, 16, architectural registers incl. PC; AW = clog2(WordCount)
ReadPorts, 3, read ports (Rn, Rm, Rd-for-store)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-low reset
pcIn  in  WordLen  current PC, returned for reads of index WordCount-1
readRegister  in  ReadPorts*AW  packed read addresses, port k at [k*AW +: AW]
readData  out  ReadPorts*WordLen  packed read data
readBusy  out  ReadPorts  port k's register has an outstanding producer
regWrite  in  1  write-back enable
writeRegister  in  AW  write-back address
writeData  in  WordLen  write-back data
issueValid  in  1  instruction with destination issued this cycle
issueRegister  in  AW  destination of issued instruction
anyBusy  out  1  OR of all busy bits
busyCount  out  AW+1  number of busy registers

Behaviour:
- Storage: WordCount-1 registers of WordLen; no storage for PC.
- Reset (rst=0, async): all registers 0, all busy bits 0. Thus readData=0 for non-PC ports, readBusy=0, anyBusy=0, busyCount=0. Reset mid-operation drops all pending writes and busy state.
- Write: rising edge with regWrite=1 and writeRegister!=WordCount-1 stores writeData. Writes to PC index are ignored, with no storage or busy change.
- Read: combinational, zero latency. Address WordCount-1 returns pcIn. Otherwise returns the stored value, subject to bypass (see Optional Feature).
- Scoreboard, per register r:
  - set when issueValid && issueRegister==r
  - clear when regWrite && writeRegister==r
  - set and clear on the same edge for the same r: set wins, because a new producer supersedes.
  - Issue to PC index: ignored, busy never set.
  - Write-back to a non-busy register: data written, busy stays 0.
- readBusy[k] = busy[addr_k], except 0 for PC index. With bypass, also 0 when regWrite && writeRegister==addr_k in the same cycle.
- busyCount: registered popcount of the busy vector, consistent with busy bits after each edge. Maximum value is WordCount-1.
- Multiple read ports may address the same register; each port returns an identical result.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: a same-cycle write-back to the read address forwards writeData to readData and suppresses readBusy for that port.
- Undefined: reads return the pre-edge stored value, and readBusy reflects raw busy. The hazard persists until the edge after write-back.
- Either way, PC reads are unaffected.

Decomposition:
- Package arm_regfile_pkg: function for AW width, constant PC_INDEX = WordCount-1, parameter defaults.
- Sub-module arm_scoreboard: owns the busy vector, set/clear priority, anyBusy and busyCount.
- Top level keeps storage, read muxing and bypass.

Test Plan:
- Reset with rst=0 for 2 cycles, pcIn=32'h100: read R3 -> 0; read R15 -> 32'h100; anyBusy=0; busyCount=0.
- Write 32'hDEADBEEF to R5, then read R5 on all 3 ports the next cycle -> all 32'hDEADBEEF. Write 32'h1 to R15 -> R15 still reads pcIn.
- Issue R2: readBusy=1 for R2 next cycle and busyCount=1. Write-back R2=32'h55 with bypass: same cycle readData=32'h55, readBusy=0. Next cycle busy clear, busyCount=0.
- Same edge issueRegister=R4 and write-back R4=32'h7 -> R4 stored as 32'h7, busy stays 1, busyCount=1.
- Issue R1, R2, R3 on consecutive cycles, then assert rst=0 asynchronously mid-cycle -> busy immediately 0, busyCount=0, R1 through R3 read 0.
- REGFILE_BYPASS_EN undefined: R6 busy, write-back 32'h9 -> same cycle readData is old value and readBusy=1; next cycle readData=32'h9 and readBusy=0.
